// File: rtl/ibuffer_pack.sv
// Packs Avalon-ST beats into fixed-width words and buffers them in a show-ahead register FIFO.
// Optional occupancy output o_level is enabled by defining IBUFFER_PACK_LEVEL_EN.
module ibuffer_pack #(
  parameter int DATA_WIDTH = 64,
  parameter int BEATS      = 2,
  parameter int DEPTH      = 16,
  parameter int DEST_WIDTH = 4,
  localparam int BEAT_W    = DATA_WIDTH + 7,
  localparam int WORD_W    = BEATS * BEAT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic                  i_sop,
  input  logic                  i_eop,
  input  logic                  i_error,
  input  logic [2:0]            i_empty,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [WORD_W-1:0]     o_data,
  output logic [DEST_WIDTH-1:0] o_dest,
  input  logic                  i_ready,
`ifdef IBUFFER_PACK_LEVEL_EN
  output logic [$clog2(DEPTH):0] o_level,
`endif
  output logic                  o_sop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(BEATS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       count_q, count_d;
  logic [SW-1:0]     slot_q, slot_d, slot_use;
  logic [WORD_W-1:0] asm_q, asm_d, word_new;
  logic              sop_err_q, sop_err_d;
  logic [BEAT_W-1:0] beat;
  logic              accept, push, pop, restart;

  assign beat      = {1'b1, i_sop, i_eop, i_empty, i_error, i_data};
  assign o_ready   = (count_q != FULL_CNT);
  assign o_valid   = (count_q != '0);
  assign accept    = i_valid && o_ready;
  assign pop       = o_valid && i_ready;
  // Gate the head so the output reads zero whenever the FIFO holds nothing.
  assign o_data    = o_valid ? mem_q[rptr_q] : '0;
  assign o_dest    = o_data[WORD_W-8 -: DEST_WIDTH];
  assign o_sop_err = sop_err_q;

`ifdef IBUFFER_PACK_LEVEL_EN
  assign o_level = count_q;
`endif

  always_comb begin
    restart   = accept && i_sop && (slot_q != '0);
    slot_use  = restart ? '0 : slot_q;
    word_new  = restart ? '0 : asm_q;
    for (int k = 0; k < BEATS; k++) begin
      if (slot_use == SW'(k)) word_new[WORD_W-1-k*BEAT_W -: BEAT_W] = beat;
    end
    push      = accept && (i_eop || (slot_use == LAST_SLOT));
    slot_d    = slot_q;
    asm_d     = asm_q;
    sop_err_d = restart;
    if (accept) begin
      // Clearing the assembly register after a push zero-fills slots of short packets.
      if (push) begin
        slot_d = '0;
        asm_d  = '0;
      end else begin
        slot_d = slot_use + 1'b1;
        asm_d  = word_new;
      end
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      slot_q    <= '0;
      asm_q     <= '0;
      sop_err_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_q + AW'(push);
      rptr_q    <= rptr_q + AW'(pop);
      count_q   <= count_d;
      slot_q    <= slot_d;
      asm_q     <= asm_d;
      sop_err_q <= sop_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= word_new;
  end

endmodule

// File: tb/tb_ibuffer_pack.sv
// Self-checking bench: two ibuffer_pack instances (BEATS=2/DEPTH=16 and BEATS=4/DEPTH=4)
// share one stimulus stream and are compared against a queue-based packet model.
module tb_ibuffer_pack;

  logic clk = 1'b0, reset = 1'b1;
  logic i_valid = 1'b0, i_sop = 1'b0, i_eop = 1'b0, i_error = 1'b0, i_ready = 1'b0;
  logic [2:0] i_empty = 3'd0;
  logic [7:0] i_data = 8'd0;

  logic        o_ready_a, o_valid_a, o_sop_err_a;
  logic [29:0] o_data_a;
  logic [3:0]  o_dest_a;
  logic        o_ready_b, o_valid_b, o_sop_err_b;
  logic [59:0] o_data_b;
  logic [3:0]  o_dest_b;
`ifdef IBUFFER_PACK_LEVEL_EN
  logic [4:0]  o_level_a;
  logic [2:0]  o_level_b;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] mq_a[$], mq_b[$];
  logic [14:0] pb_a[$], pb_b[$];

  always #5 clk = ~clk;

  ibuffer_pack #(.DATA_WIDTH(8), .BEATS(2), .DEPTH(16), .DEST_WIDTH(4)) dut_a (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_sop(i_sop), .i_eop(i_eop),
    .i_error(i_error), .i_empty(i_empty), .i_data(i_data), .o_ready(o_ready_a),
    .o_valid(o_valid_a), .o_data(o_data_a), .o_dest(o_dest_a), .i_ready(i_ready),
`ifdef IBUFFER_PACK_LEVEL_EN
    .o_level(o_level_a),
`endif
    .o_sop_err(o_sop_err_a)
  );

  ibuffer_pack #(.DATA_WIDTH(8), .BEATS(4), .DEPTH(4), .DEST_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_sop(i_sop), .i_eop(i_eop),
    .i_error(i_error), .i_empty(i_empty), .i_data(i_data), .o_ready(o_ready_b),
    .o_valid(o_valid_b), .o_data(o_data_b), .o_dest(o_dest_b), .i_ready(i_ready),
`ifdef IBUFFER_PACK_LEVEL_EN
    .o_level(o_level_b),
`endif
    .o_sop_err(o_sop_err_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Checks one instance's outputs against the model, then advances the model by one clock.
  task automatic model_step(input int inst, input logic obs_ready, input logic obs_valid,
                            input logic [63:0] obs_data, input logic [3:0] obs_dest,
                            input logic [63:0] obs_level, output logic err);
    logic [63:0] q[$];
    logic [14:0] pb[$];
    int depth, beats, ww;
    logic [63:0] head, w;
    logic acc, pop;
    string nm;
    if (inst == 0) begin
      q = mq_a; pb = pb_a; depth = 16; beats = 2; ww = 30; nm = "a";
    end else begin
      q = mq_b; pb = pb_b; depth = 4; beats = 4; ww = 60; nm = "b";
    end
    head = (q.size() != 0) ? q[0] : 64'd0;
    chk({nm, "_ready"}, 64'(obs_ready), 64'(q.size() != depth));
    chk({nm, "_valid"}, 64'(obs_valid), 64'(q.size() != 0));
    chk({nm, "_data"}, obs_data, head);
    chk({nm, "_dest"}, 64'(obs_dest), (head >> (ww - 11)) & 64'hF);
`ifdef IBUFFER_PACK_LEVEL_EN
    chk({nm, "_level"}, obs_level, 64'(q.size()));
`endif
    acc = i_valid && (q.size() != depth);
    pop = (q.size() != 0) && i_ready;
    err = 1'b0;
    if (pop) void'(q.pop_front());
    if (acc) begin
      if (i_sop && pb.size() != 0) begin
        err = 1'b1;
        pb.delete();
      end
      pb.push_back({1'b1, i_sop, i_eop, i_empty, i_error, i_data});
      if (i_eop || pb.size() == beats) begin
        w = 64'd0;
        for (int k = 0; k < pb.size(); k++) w |= 64'(pb[k]) << (ww - (k + 1) * 15);
        q.push_back(w);
        pb.delete();
      end
    end
    if (inst == 0) begin
      mq_a = q; pb_a = pb;
    end else begin
      mq_b = q; pb_b = pb;
    end
  endtask

  task automatic cycle();
    logic ea, eb;
    logic [63:0] la, lb;
    la = 64'd0;
    lb = 64'd0;
`ifdef IBUFFER_PACK_LEVEL_EN
    la = 64'(o_level_a);
    lb = 64'(o_level_b);
`endif
    model_step(0, o_ready_a, o_valid_a, 64'(o_data_a), o_dest_a, la, ea);
    model_step(1, o_ready_b, o_valid_b, 64'(o_data_b), o_dest_b, lb, eb);
    @(posedge clk);
    #1;
    chk("a_sop_err", 64'(o_sop_err_a), 64'(ea));
    chk("b_sop_err", 64'(o_sop_err_b), 64'(eb));
  endtask

  task automatic send(input logic v, input logic s, input logic e, input logic [7:0] d,
                      input logic rdy);
    i_valid = v;
    i_sop   = s;
    i_eop   = e;
    i_data  = d;
    i_ready = rdy;
    i_empty = 3'($urandom_range(7));
    i_error = 1'($urandom_range(1));
    cycle();
  endtask

  task automatic drain(input int n);
    repeat (n) send(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_a_valid", 64'(o_valid_a), 64'd0);
    chk("rst_a_ready", 64'(o_ready_a), 64'd1);
    chk("rst_a_data", 64'(o_data_a), 64'd0);
    chk("rst_a_err", 64'(o_sop_err_a), 64'd0);
    chk("rst_b_valid", 64'(o_valid_b), 64'd0);
    chk("rst_b_ready", 64'(o_ready_b), 64'd1);
    chk("rst_b_data", 64'(o_data_b), 64'd0);
    chk("rst_b_err", 64'(o_sop_err_b), 64'd0);
    mq_a.delete(); mq_b.delete(); pb_a.delete(); pb_b.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // Two-beat packet on the BEATS=2 instance; early eop on the BEATS=4 instance.
    send(1'b1, 1'b1, 1'b0, 8'h0A, 1'b1);
    send(1'b1, 1'b0, 1'b1, 8'h0B, 1'b1);
    chk("r034_valid", 64'(o_valid_a), 64'd1);
    chk("r034_b0", 64'(o_data_a[22:15]), 64'h0A);
    chk("r034_b1", 64'(o_data_a[7:0]), 64'h0B);
    send(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    chk("r034_one", 64'(o_valid_a), 64'd0);

    drain(3);
    send(1'b1, 1'b1, 1'b1, 8'h05, 1'b1);
    chk("r035_valid", 64'(o_valid_b), 64'd1);
    chk("r035_d0", 64'(o_data_b[52:45]), 64'h05);
    chk("r035_zero", 64'(o_data_b[44:0]), 64'd0);

    drain(3);
    for (int i = 0; i < 4; i++) send(1'b1, 1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
    chk("r036_full", 64'(o_ready_b), 64'd0);
    send(1'b1, 1'b1, 1'b1, 8'h50, 1'b0);
    chk("r036_stall", 64'(o_ready_b), 64'd0);
    chk("r036_head", 64'(o_data_b[52:45]), 64'h40);
    send(1'b1, 1'b1, 1'b1, 8'h50, 1'b1);
    chk("r036_free", 64'(o_ready_b), 64'd1);
    chk("r036_next", 64'(o_data_b[52:45]), 64'h41);
    drain(24);

    send(1'b1, 1'b1, 1'b0, 8'h11, 1'b1);
    send(1'b1, 1'b0, 1'b0, 8'h22, 1'b1);
    send(1'b1, 1'b1, 1'b0, 8'h33, 1'b1);
    chk("r037_err", 64'(o_sop_err_b), 64'd1);
    chk("r037_noerr_a", 64'(o_sop_err_a), 64'd0);
    send(1'b1, 1'b0, 1'b1, 8'h44, 1'b1);
    chk("r037_pulse", 64'(o_sop_err_b), 64'd0);
    chk("r037_d0", 64'(o_data_b[52:45]), 64'h33);
    chk("r037_d1", 64'(o_data_b[37:30]), 64'h44);

    drain(4);
    send(1'b1, 1'b1, 1'b1, 8'h61, 1'b0);
    send(1'b1, 1'b1, 1'b1, 8'h62, 1'b1);
    chk("r038_valid", 64'(o_valid_b), 64'd1);
    chk("r038_head", 64'(o_data_b[52:45]), 64'h62);
    send(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    chk("r038_cnt1", 64'(o_valid_b), 64'd0);

    drain(3);
    send(1'b1, 1'b1, 1'b0, 8'h71, 1'b1);
    do_reset();
    chk("r039_valid", 64'(o_valid_a), 64'd0);
    send(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    chk("r039_none", 64'(o_valid_a), 64'd0);
    send(1'b1, 1'b1, 1'b0, 8'h72, 1'b1);
    send(1'b1, 1'b0, 1'b1, 8'h73, 1'b1);
    chk("r039_b0", 64'(o_data_a[22:15]), 64'h72);
    chk("r039_b1", 64'(o_data_a[7:0]), 64'h73);
    chk("r039_sop", 64'(o_data_a[28]), 64'd1);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(299) == 0) do_reset();
      else send(1'($urandom_range(9) < 7), 1'($urandom_range(3) == 0),
                1'($urandom_range(9) < 3), 8'($urandom), 1'($urandom_range(9) < 6));
    end
    drain(24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
